// File: rtl/line_buffer_3row_pkg.sv
// Shared image-pipeline parameters and helpers.
// Holds the default frame geometry (RGB888, 480x272) that both the 3-row
// line buffer and the 3x3 matrix stage use, so the two blocks cannot
// drift apart. Also provides the counter-width helper.
package line_buffer_3row_pkg;

  localparam int WIDTH_DEF      = 24;
  localparam int PIC_WIDTH_DEF  = 480;
  localparam int PIC_HEIGHT_DEF = 272;

  // Width of a counter that must hold 0..n-1. Never returns 0, so a
  // degenerate 1- or 2-entry geometry still yields a legal vector.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int COL_W_DEF = cnt_w(PIC_WIDTH_DEF);
  localparam int ROW_W_DEF = cnt_w(PIC_HEIGHT_DEF);

endpackage

// File: rtl/line_buffer_3row_line_delay_ram.sv
// line_delay_ram: one line of pixel delay.
// Single-port, read-first memory of DEPTH words of WIDTH bits. The read
// port returns the word currently stored at addr_i; a write on the same
// clock lands at the edge, so a read at the written address sees the
// OLD word (read-first).
// Ports:
//   clk      in   clock
//   en_i     in   write enable (one write per valid pixel)
//   addr_i   in   column address
//   wdata_i  in   word to store at addr_i
//   rdata_o  out  word stored at addr_i before this cycle's write
module line_delay_ram #(
  parameter int WIDTH  = 24,
  parameter int DEPTH  = 480,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);

  // Contents are never cleared: the first two lines of every frame
  // overwrite whatever is left before any of it reaches a valid output.
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/line_buffer_3row.sv
// line_buffer_3row: turns one raster-order pixel stream into three
// vertically aligned row streams for the 3x3 window stage.
//   dout3 = current pixel, dout2 = same column one line up,
//   dout1 = same column two lines up.
// Stream protocol: valid-only, no back-pressure. A pixel is taken on
// every clock where valid_in is high; valid_out marks the cycle its
// aligned column appears on dout1..3, exactly one clock later. With
// valid_in low all state holds and valid_out drops.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   sof          start-of-frame: column/row counters restart at 0
//   valid_in     din carries a pixel this cycle
//   din          input pixel
//   dout1..3     aligned column (two up, one up, current)
//   valid_out    dout1..3 valid this cycle
//   frame_done   pulse alongside the last valid_out of a frame
module line_buffer_3row
  import line_buffer_3row_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int PIC_WIDTH  = PIC_WIDTH_DEF,
  parameter int PIC_HEIGHT = PIC_HEIGHT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sof,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic             valid_out,
  output logic             frame_done
);

  localparam int COL_W = cnt_w(PIC_WIDTH);
  localparam int ROW_W = cnt_w(PIC_HEIGHT);

  localparam logic [COL_W-1:0] LAST_COL      = COL_W'(PIC_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW      = ROW_W'(PIC_HEIGHT - 1);
  // Rows 0 and 1 only prime the two line delays.
  localparam logic [ROW_W-1:0] FIRST_OUT_ROW = ROW_W'(2);

  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic [ROW_W-1:0] row_q, row_d, cur_row;
  logic [WIDTH-1:0] dout1_q, dout2_q, dout3_q;
  logic             valid_out_q, frame_done_q;
  logic [WIDTH-1:0] line_a_rd, line_b_rd;
  logic             last_pix;

  // sof takes effect on its own cycle: a pixel arriving with sof is
  // already column 0 / row 0.
  always_comb begin
    cur_col = sof ? '0 : col_q;
    cur_row = sof ? '0 : row_q;
    col_d   = cur_col;
    row_d   = cur_row;
    if (valid_in) begin
      if (cur_col == LAST_COL) begin
        col_d = '0;
        row_d = (cur_row == LAST_ROW) ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
      end
    end
  end

  assign last_pix = (cur_col == LAST_COL) && (cur_row == LAST_ROW);

  // Delay A holds line n-1; delay B takes A's outgoing word so it
  // holds line n-2.
  line_delay_ram #(
    .WIDTH (WIDTH),
    .DEPTH (PIC_WIDTH),
    .ADDR_W(COL_W)
  ) u_line_a (
    .clk    (clk),
    .en_i   (valid_in),
    .addr_i (cur_col),
    .wdata_i(din),
    .rdata_o(line_a_rd)
  );

  line_delay_ram #(
    .WIDTH (WIDTH),
    .DEPTH (PIC_WIDTH),
    .ADDR_W(COL_W)
  ) u_line_b (
    .clk    (clk),
    .en_i   (valid_in),
    .addr_i (cur_col),
    .wdata_i(line_a_rd),
    .rdata_o(line_b_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      dout1_q      <= '0;
      dout2_q      <= '0;
      dout3_q      <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      valid_out_q  <= valid_in && (cur_row >= FIRST_OUT_ROW);
      frame_done_q <= valid_in && last_pix;
      if (valid_in) begin
        dout1_q <= line_b_rd;
        dout2_q <= line_a_rd;
        dout3_q <= din;
      end
    end
  end

  assign dout1      = dout1_q;
  assign dout2      = dout2_q;
  assign dout3      = dout3_q;
  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/line_buffer_3row.md
Name: line_buffer_3row

Overview:
Converts a single raster-order pixel stream into three vertically aligned row streams for the 3x3 window/filter stage (laplacian and similar).
- dout3 carries the current line.
- dout2 carries the previous line, same column.
- dout1 carries the line before that, same column.
- The block sits between the camera/frame source and the matrix stage, and drives its valid_in/din1/din2/din3 directly.

Parameters:
WIDTH, 24, pixel width in bits (RGB888; filter uses [7:0])
PIC_WIDTH, 480, pixels per line
PIC_HEIGHT, 272, lines per frame

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
sof  in  1  start-of-frame pulse; forces column and row counters to 0
valid_in  in  1  din is a valid pixel this cycle
din  in  WIDTH  input pixel, raster order
dout1  out  WIDTH  pixel two lines above current, same column
dout2  out  WIDTH  pixel one line above current, same column
dout3  out  WIDTH  current pixel
valid_out  out  1  dout1..dout3 valid this cycle
frame_done  out  1  one-cycle pulse with the last valid_out of a frame

Behaviour:
Reset values:
- dout1/dout2/dout3 = 0; valid_out = 0; frame_done = 0.
- col = 0; row = 0.
- Line RAM contents are not cleared and need not be.

Counters (advance only on valid_in = 1):
- col: 0..PIC_WIDTH-1. Wraps to 0 after PIC_WIDTH-1; the wrap increments row.
- row: 0..PIC_HEIGHT-1. Wraps to 0 after the last pixel of line PIC_HEIGHT-1.
- valid_in = 0 holds all state; gaps inside a line are allowed.

sof:
- sof alone: col = row = 0 next cycle.
- sof with valid_in: that pixel is col 0, row 0; counters become col = 1, row = 0.
- sof mid-frame aborts the frame. frame_done does not fire for the aborted frame.

Line storage:
- Two line delays, each PIC_WIDTH deep, addressed by col.
- Delay A holds line n-1; delay B holds line n-2.
- On valid_in at column c:
  - read A[c] and B[c];
  - write A[c] <= din and B[c] <= old A[c].
- Read-during-write to the same address returns the OLD data (read-first).

Outputs (registered, latency exactly 1 clk from valid_in):
- dout3 <= din; dout2 <= A[c] (old); dout1 <= B[c] (old).
- valid_out <= valid_in && (row >= 2). Rows 0 and 1 are priming and produce no valid_out.
- Each frame yields (PIC_HEIGHT-2)*PIC_WIDTH valid_out cycles.
- When valid_in = 0: valid_out <= 0 and dout1..3 hold.

frame_done:
- Next cycle after valid_in at col = PIC_WIDTH-1, row = PIC_HEIGHT-1, coincident with that pixel's valid_out.

Reset mid-operation:
- All counters and outputs return to reset values immediately (async).
- The next frame must re-prime two lines.

Widths:
- Counters are sized with $clog2 of PIC_WIDTH and PIC_HEIGHT.
- Comparisons use parameter-derived constants; no truncating literals.

Decomposition:
Shared package / header (img_pkg):
- WIDTH, PIC_WIDTH, PIC_HEIGHT defaults, reused by matrix_3x3 and this block.
- COL_W = $clog2(PIC_WIDTH) and ROW_W = $clog2(PIC_HEIGHT).

Sub-module line_delay_ram:
- Single-port read-first RAM, depth PIC_WIDTH, width WIDTH, with enable.
- Instantiated twice (A and B) and inferable as block RAM.
- Counters, output registers and frame_done logic stay in the top.

Test Plan:
All scenarios use bench params PIC_WIDTH=4, PIC_HEIGHT=4 and pixel value din = row*16 + col.
1. Full frame, valid_in continuous:
   - No valid_out for the first 8 pixels.
   - Pixel (2,0) -> 1 clk later dout3=0x20, dout2=0x10, dout1=0x00, valid_out=1.
   - Pixel (3,3) -> dout3=0x33, dout2=0x23, dout1=0x13, frame_done=1.
   - Exactly 8 valid_out cycles in total.
2. Same frame with valid_in toggling 1/0 every cycle:
   - Identical dout sequence to scenario 1.
   - valid_out is never high on a cycle following valid_in = 0.
   - frame_done occurs once.
3. Two back-to-back frames, second frame din = 0x80 + row*16 + col:
   - Row 2 of frame 2 gives dout1=0x80, dout2=0x90, dout3=0xA0.
   - No valid_out during frame 2 rows 0–1.
4. sof asserted with valid_in at pixel (1,2) of frame 1:
   - That pixel restarts as (0,0).
   - No valid_out for the next 8 valid pixels.
   - No frame_done for the aborted frame.
5. rst_n low for 1 clk at pixel (2,1):
   - All outputs 0 at once.
   - After release, a fresh frame produces its first valid_out at its pixel (2,0).
6. valid_in held 0 for 20 cycles mid-line at col 2:
   - dout1..3 hold their values and valid_out stays 0.
   - On resume, output continues at col 2 with the correct vertical alignment.
